// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment serial output engine.
// Holds the segment patterns for BCD 0-9 and blank, the serialiser state
// encoding, the segment byte width and a byte bit-reversal helper.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;

  // Segment byte layout is {dp,g,f,e,d,c,b,a}; the dp bit is left clear here.
  localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Mirror a segment byte so that bit0 lands in the MSB position.
  function automatic logic [SEG_W-1:0] bit_rev(input logic [SEG_W-1:0] b);
    logic [SEG_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SEG_W); i++) begin
      r[i] = b[SEG_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to segment byte decoder (dp bit always 0).
// Ports: bcd   - 4-bit BCD code; codes 10-15 decode to blank.
//        seg_c - segment byte {dp,g,f,e,d,c,b,a}, active-high.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_serial_out.sv
// N-digit 7-segment serial output engine. On a start strobe it snapshots the
// BCD digits and decimal points, decodes/blanks/inverts them into segment
// bytes and shifts them MSD first to daisy-chained shift registers, then
// pulses the storage latch and a one-cycle completion strobe.
// Ports: i_clk, i_reset_n (async active-low), i_en (low freezes everything),
//        i_start_stb, i_digits[4*N], i_dp[N] -> o_busy, o_done_stb,
//        o_serial_data, o_serial_clk, o_serial_latch (all registered).
module seg7_serial_out
  import seg7_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ    = 5_000_000,
  parameter int unsigned SHIFT_CLK_HZ  = 1_000_000,
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned LSB_FIRST     = 0,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_en,
  input  logic                    i_start_stb,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic                    o_busy,
  output logic                    o_done_stb,
  output logic                    o_serial_data,
  output logic                    o_serial_clk,
  output logic                    o_serial_latch
);

  localparam int unsigned DIV   = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
  localparam int unsigned DIV_W = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam int unsigned NBITS = SEG_W * NUM_DIGITS;
  localparam int unsigned BIT_W = $clog2(NBITS + 1);

  // Elaboration guards on the parameter space.
  if (DIV < 1) begin : g_bad_div
    $error("seg7_serial_out: SYS_CLK_HZ must be at least 2*SHIFT_CLK_HZ");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg7_serial_out: NUM_DIGITS must be in 1..16");
  end

  // Per-digit segment decode.
  logic [SEG_W-1:0] seg_raw [NUM_DIGITS];

  for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_dec
    bcd_to_seg7 u_dec (
      .bcd   (i_digits[4*k +: 4]),
      .seg_c (seg_raw[k])
    );
  end

  // Build the frame: blank leading zeros, add dp, invert, order bits.
  logic [NBITS-1:0] frame_c;
  logic [SEG_W-1:0] byte_c;
  logic             lead_c;

  always_comb begin
    frame_c = '0;
    byte_c  = '0;
    lead_c  = (BLANK_LEADING != 0);
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      if (lead_c && (k != 0) && (i_digits[4*k +: 4] == 4'd0)) begin
        byte_c = {i_dp[k], 7'b0};
      end else begin
        lead_c = 1'b0;
        byte_c = seg_raw[k] | {i_dp[k], 7'b0};
      end
      if (ACTIVE_LOW != 0) byte_c = ~byte_c;
      // The shifter always emits its MSB, so LSB-first bytes are pre-mirrored.
      if (LSB_FIRST != 0) byte_c = bit_rev(byte_c);
      frame_c[SEG_W*k +: SEG_W] = byte_c;
    end
  end

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [NBITS-1:0]  shreg, shreg_nx;
  logic              div_last;
  logic              busy_nx, done_nx, data_nx, sclk_nx, latch_nx;

  assign div_last = (div_cnt == DIV_W'(DIV - 1));

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= ST_IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      o_busy         <= 1'b0;
      o_done_stb     <= 1'b0;
      o_serial_data  <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
    end else begin
      state          <= state_nx;
      div_cnt        <= div_cnt_nx;
      bit_cnt        <= bit_cnt_nx;
      shreg          <= shreg_nx;
      o_busy         <= busy_nx;
      o_done_stb     <= done_nx;
      o_serial_data  <= data_nx;
      o_serial_clk   <= sclk_nx;
      o_serial_latch <= latch_nx;
    end
  end

  // Next-state and next-output logic; i_en low leaves everything unchanged.
  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    data_nx    = o_serial_data;

    if (i_en) begin
      case (state)
        ST_IDLE: begin
          if (i_start_stb) begin
            state_nx   = ST_LOW;
            shreg_nx   = frame_c;
            bit_cnt_nx = '0;
            div_cnt_nx = '0;
          end
        end
        ST_LOW: begin
          if (div_last) begin
            state_nx   = ST_HIGH;
            div_cnt_nx = '0;
          end else begin
            div_cnt_nx = div_cnt + DIV_W'(1);
          end
        end
        ST_HIGH: begin
          if (div_last) begin
            div_cnt_nx = '0;
            shreg_nx   = shreg << 1;
            bit_cnt_nx = bit_cnt + BIT_W'(1);
            state_nx   = (bit_cnt == BIT_W'(NBITS - 1)) ? ST_LATCH : ST_LOW;
          end else begin
            div_cnt_nx = div_cnt + DIV_W'(1);
          end
        end
        ST_LATCH: begin
          if (div_last) begin
            state_nx   = ST_DONE;
            div_cnt_nx = '0;
          end else begin
            div_cnt_nx = div_cnt + DIV_W'(1);
          end
        end
        ST_DONE: begin
          state_nx = ST_IDLE;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase

      // Data updates only on entry to LOW, so it is settled before the clock rises.
      if ((state_nx == ST_LOW) && (state != ST_LOW)) begin
        data_nx = shreg_nx[NBITS-1];
      end else if ((state_nx != ST_LOW) && (state_nx != ST_HIGH)) begin
        data_nx = 1'b0;
      end
    end

    busy_nx  = (state_nx != ST_IDLE);
    done_nx  = (state_nx == ST_DONE);
    sclk_nx  = (state_nx == ST_HIGH);
    latch_nx = (state_nx == ST_LATCH);
  end

endmodule
